ef_spi_slave: RTL and testbench
===============================

# ef_spi_slave

SPI responder (slave) core: the far end of the EF_SPI controller's `sclk`/`csb`/`dout`/`din` link. It receives MOSI words, returns MISO words from a one-entry transmit holding register, and exposes valid/ready user ports. It supports all four CPOL/CPHA modes, MSB first. It oversamples the serial pins on the system clock and serves as the bench responder and as a reusable on-chip SPI target.

## Interface
- `DW`, 8: word width in bits (≥ 4).
- `IDLE_WORD`, 8'hFF: word shifted out on transmit underrun.
- `clk` in 1: system clock; the only clock. `sclk` is treated as data.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpol` in 1: SCK idle level. Latched at frame start.
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge. Latched at frame start.
- `sclk` in 1: serial clock from the master.
- `csb` in 1: chip select, active-low.
- `mosi` in 1: serial data from the master (the master's `dout`).
- `miso` out 1: serial data to the master (the master's `din`).
- `miso_oe` out 1: high while selected.
- `tx_data` in DW, `tx_valid` in 1, `tx_ready` out 1: transmit word handshake.
- `rx_data` out DW, `rx_valid` out 1: received word; `rx_valid` is a 1-cycle pulse with no backpressure.
- `tx_underrun` out 1: 1-cycle pulse when a word load finds the holding register empty.
- `frame_err` out 1: 1-cycle pulse when `csb` rises mid-word.
- `busy` out 1: high in ACTIVE.

## Operation
- Synchronisers: `sclk`, `csb` and `mosi` each pass through a 2-flop synchroniser. Reset values are `sclk`=`cpol`-independent 0, `csb`=1, `mosi`=0.
- Edge detection: a third flop on synced `sclk`/`csb` detects edges.
  - Leading edge = transition away from the latched `cpol`; trailing edge = the return.
  - Sample edge = leading if `cpha`=0, else trailing. Shift edge = the other one.
- Holding register: `tx_ready` = holding empty. A handshake occurs when `tx_valid & tx_ready`; that cycle the holding register captures `tx_data` and becomes full.
- Word load (into `tx_shift`):
  - If holding is full, take the holding word and mark holding empty.
  - Otherwise take `IDLE_WORD` and pulse `tx_underrun`.
- `miso` = `tx_shift[DW-1]` at all times. `miso_oe` = (state == ACTIVE).
- States:
  - IDLE: requires `armed`. `armed` is set when synced `csb` is seen high, and cleared by reset. On a synced `csb` fall with `armed`: latch `cpol`/`cpha`, set `bitcnt`=0, do a word load, go to ACTIVE.
  - ACTIVE, sample edge: `rx_shift` <= {`rx_shift`[DW-2:0], `mosi_s`}; `bitcnt`++. When `bitcnt` reaches DW: capture `rx_data` = the completed word, pulse `rx_valid` next cycle, set `bitcnt`=0, do a word load.
  - ACTIVE, shift edge: shift `tx_shift` left by one only if `bitcnt` ≠ 0. This makes CPHA=1 hold the MSB on the first leading edge, and makes CPHA=0 keep the freshly loaded word.
  - ACTIVE, synced `csb` rise: go to IDLE. If `bitcnt` ≠ 0, pulse `frame_err` and discard the partial word. No `rx_valid` for the partial word.
- Simultaneous handshake and word load: the load sees the holding state from before the handshake (no bypass). An empty holding register therefore underruns while the incoming word is stored for the next load.
- Changes to `cpol`/`cpha` while ACTIVE are ignored.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `tx_underrun`=0, `frame_err`=0, `busy`=0, state IDLE, `armed`=0.
- Pin-to-event latency: 3 `clk` cycles (2 sync + 1 edge).
  - `miso` shows the new MSB 4 cycles after the `csb` fall.
  - `rx_valid` rises 4 cycles after the final sample edge at the pin.
- Constraints on the master:
  - Each SCK half-period ≥ 4 `clk` periods.
  - `csb` fall to the first SCK edge ≥ 4 `clk` periods.
  - Last SCK edge to the `csb` rise ≥ 4 `clk` periods.
- Back-to-back words need no gap. The next word is loaded on the same cycle as the completing sample edge.
- Reset mid-frame aborts immediately with no pulses. The block stays IDLE until `csb` is seen high, so it never joins a frame in progress.

## Structure
- Package `ef_spi_slave_pkg`:
  - state enum (`ST_IDLE`, `ST_ACTIVE`)
  - `SYNC_STAGES` = 2
  - default `DW` and `IDLE_WORD` constants
- Sub-module `ef_spi_slave_sync`: parameterised-reset-value 2-flop synchroniser, instantiated three times.

## Test plan
- Mode 0, `clk`:SCK = 8:1: preload 8'hA5, master sends 8'h3C. Required: `rx_data`=8'h3C with one `rx_valid` pulse; master receives 8'hA5; `tx_ready` returns to 1 at frame start.
- All four CPOL/CPHA modes: 2-word burst, preloads 8'h81 then 8'h7E, master sends 8'h12, 8'h34. Required: exact round trip of both words in each mode; no `tx_underrun`.
- No preload: master sends 8'h55. Required: master receives 8'hFF; one `tx_underrun` pulse at frame start; `rx_data`=8'h55.
- `csb` raised after 5 bits. Required: one `frame_err` pulse; no `rx_valid`; the next full frame is received correctly.
- `rst_n` asserted mid-frame and released while `csb` is still low. Required: all outputs at reset values; no `rx_valid` until `csb` goes high and a new frame starts.
- `tx_valid` pulsed on the same cycle as the frame-start load with holding empty, data 8'hC3. Required: current word is 8'hFF with `tx_underrun`; the next word is 8'hC3.

Source files
------------

// File: rtl/ef_spi_slave_pkg.sv
// Shared types and constants for the SPI responder core.
package ef_spi_slave_pkg;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned DW_DEF        = 8;
    localparam logic [7:0]  IDLE_WORD_DEF = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/ef_spi_slave_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with a selectable reset value.
module ef_spi_slave_sync
    import ef_spi_slave_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_ff;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ff <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_ff <= {r_ff[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[SYNC_STAGES-1];

endmodule

// File: rtl/ef_spi_slave.sv
// SPI responder: oversamples sclk/csb/mosi on clk, all four CPOL/CPHA modes, MSB first,
// with a one-entry transmit holding register.
module ef_spi_slave
    import ef_spi_slave_pkg::*;
#(
    parameter int unsigned   DW        = DW_DEF,
    parameter logic [DW-1:0] IDLE_WORD = DW'(IDLE_WORD_DEF)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpol,
    input  logic          i_cpha,
    input  logic          i_sclk,
    input  logic          i_csb,
    input  logic          i_mosi,
    output logic          o_miso,
    output logic          o_miso_oe,
    input  logic [DW-1:0] i_tx_data,
    input  logic          i_tx_valid,
    output logic          o_tx_ready,
    output logic [DW-1:0] o_rx_data,
    output logic          o_rx_valid,
    output logic          o_tx_underrun,
    output logic          o_frame_err,
    output logic          o_busy
);

    localparam int unsigned CW = $clog2(DW);
    localparam int unsigned WW = $clog2(SYNC_STAGES + 1);

    logic w_sclk_s, w_csb_s, w_mosi_s;

    ef_spi_slave_sync #(.RST_VAL(1'b0)) u_sync_sclk (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk), .o_q(w_sclk_s));
    ef_spi_slave_sync #(.RST_VAL(1'b1)) u_sync_csb  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_csb),  .o_q(w_csb_s));
    ef_spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi), .o_q(w_mosi_s));

    state_t          r_state, w_state_nxt;
    logic            r_sclk_d, r_csb_d;
    logic [WW-1:0]   r_warm, w_warm_nxt;
    logic            r_armed, w_armed_nxt;
    logic            r_cpol, w_cpol_nxt, r_cpha, w_cpha_nxt;
    logic [CW-1:0]   r_bitcnt, w_bitcnt_nxt;
    logic [DW-1:0]   r_rx_shift, w_rx_shift_nxt, r_tx_shift, w_tx_shift_nxt;
    logic [DW-1:0]   r_hold, w_hold_nxt, r_rx_data, w_rx_data_nxt;
    logic            r_hold_full, w_hold_full_nxt;
    logic            r_rx_valid, w_rx_valid_nxt, r_underrun, w_underrun_nxt;
    logic            r_frame_err, w_frame_err_nxt;
    logic            w_load, w_hs, w_warm_done;
    logic            w_sclk_edge, w_lead, w_trail, w_sample, w_shift, w_csb_fall, w_csb_rise;
    logic [DW-1:0]   w_rx_word;

    assign w_sclk_edge = w_sclk_s ^ r_sclk_d;
    assign w_lead      = w_sclk_edge & (w_sclk_s ^ r_cpol);
    assign w_trail     = w_sclk_edge & ~(w_sclk_s ^ r_cpol);
    assign w_sample    = r_cpha ? w_trail : w_lead;
    assign w_shift     = r_cpha ? w_lead : w_trail;
    assign w_csb_fall  = ~w_csb_s & r_csb_d;
    assign w_csb_rise  = w_csb_s & ~r_csb_d;
    assign w_hs        = i_tx_valid & ~r_hold_full;
    assign w_rx_word   = {r_rx_shift[DW-2:0], w_mosi_s};
    // Synchroniser reset values are not real pin levels; only arm once they have flushed.
    assign w_warm_done = (r_warm == WW'(SYNC_STAGES));

    always_comb begin
        w_state_nxt     = r_state;
        w_warm_nxt      = w_warm_done ? r_warm : r_warm + WW'(1);
        w_armed_nxt     = r_armed | (w_warm_done & w_csb_s);
        w_cpol_nxt      = r_cpol;
        w_cpha_nxt      = r_cpha;
        w_bitcnt_nxt    = r_bitcnt;
        w_rx_shift_nxt  = r_rx_shift;
        w_tx_shift_nxt  = r_tx_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_underrun_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_csb_fall && r_armed) begin
                    w_cpol_nxt   = i_cpol;
                    w_cpha_nxt   = i_cpha;
                    w_bitcnt_nxt = '0;
                    w_load       = 1'b1;
                    w_state_nxt  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_csb_rise) begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_err_nxt = (r_bitcnt != '0);
                    w_bitcnt_nxt    = '0;
                end else if (w_sample) begin
                    w_rx_shift_nxt = w_rx_word;
                    if (r_bitcnt == CW'(DW - 1)) begin
                        w_rx_data_nxt  = w_rx_word;
                        w_rx_valid_nxt = 1'b1;
                        w_bitcnt_nxt   = '0;
                        w_load         = 1'b1;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + CW'(1);
                    end
                end else if (w_shift && r_bitcnt != '0) begin
                    w_tx_shift_nxt = {r_tx_shift[DW-2:0], 1'b0};
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Handshake and load never both touch the holding register: one needs it empty, the other full.
        if (w_hs) begin
            w_hold_nxt      = i_tx_data;
            w_hold_full_nxt = 1'b1;
        end
        if (w_load) begin
            if (r_hold_full) begin
                w_tx_shift_nxt  = r_hold;
                w_hold_full_nxt = 1'b0;
            end else begin
                w_tx_shift_nxt = IDLE_WORD;
                w_underrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sclk_d    <= 1'b0;
            r_csb_d     <= 1'b1;
            r_warm      <= '0;
            r_armed     <= 1'b0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_bitcnt    <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sclk_d    <= w_sclk_s;
            r_csb_d     <= w_csb_s;
            r_warm      <= w_warm_nxt;
            r_armed     <= w_armed_nxt;
            r_cpol      <= w_cpol_nxt;
            r_cpha      <= w_cpha_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_underrun  <= w_underrun_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign o_miso        = r_tx_shift[DW-1];
    assign o_miso_oe     = (r_state == ST_ACTIVE);
    assign o_busy        = (r_state == ST_ACTIVE);
    assign o_tx_ready    = ~r_hold_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_underrun;
    assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_ef_spi_slave.sv
// Directed bench: drives the responder as an SPI master and checks words, pulses and reset behaviour.
module tb_ef_spi_slave;

    logic       clk, rst_n, cpol, cpha, sclk, csb, mosi;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err, busy;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid;

    int checks = 0;
    int failures = 0;
    int rx_cnt = 0;
    int under_cnt = 0;
    int ferr_cnt = 0;
    int u_mark = 0;
    logic [7:0] rx_log [16];

    ef_spi_slave dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpol(cpol), .i_cpha(cpha),
        .i_sclk(sclk), .i_csb(csb), .i_mosi(mosi),
        .o_miso(miso), .o_miso_oe(miso_oe),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .o_tx_underrun(tx_underrun), .o_frame_err(frame_err), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_log[rx_cnt % 16] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_underrun === 1'b1) under_cnt <= under_cnt + 1;
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            wait_clk(1);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin failures++; $display("FAIL load_tx_ready got=%b exp=1", tx_ready); end
        tx_data = d; tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic frame_start(input logic pol, input logic pha);
        cpol = pol; cpha = pha; sclk = pol;
        wait_clk(6);
        csb = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        wait_clk(6);
        csb = 1'b1;
        wait_clk(8);
    endtask

    // Master side: half-period of 4 clk; u_mark snapshots underruns just before the last sample edge.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = tx[7-i];
                wait_clk(4);
                if (i == 7) u_mark = under_cnt;
                rx = {rx[6:0], miso};
                sclk = ~cpol;
                wait_clk(4);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = tx[7-i];
                wait_clk(4);
                if (i == 7) u_mark = under_cnt;
                rx = {rx[6:0], miso};
                sclk = cpol;
                wait_clk(4);
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (miso !== 1'b0)     begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
        checks++; if (miso_oe !== 1'b0)  begin failures++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mode0();
        logic [7:0] m;
        int r0, u0;
        r0 = rx_cnt; u0 = under_cnt;
        load_tx(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL m0_ready_full got=%b exp=0", tx_ready); end
        frame_start(1'b0, 1'b0);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL m0_ready_start got=%b exp=1", tx_ready); end
        checks++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin failures++; $display("FAIL m0_busy got=%b/%b exp=1/1", busy, miso_oe); end
        spi_xfer(8'h3C, 8, m);
        frame_end();
        checks++; if (m !== 8'hA5) begin failures++; $display("FAIL m0_master_rx got=%h exp=a5", m); end
        checks++; if (rx_cnt - r0 != 1) begin failures++; $display("FAIL m0_rx_pulses got=%0d exp=1", rx_cnt - r0); end
        checks++; if (rx_log[r0 % 16] !== 8'h3C) begin failures++; $display("FAIL m0_rx_data got=%h exp=3c", rx_log[r0 % 16]); end
        checks++; if (u_mark - u0 != 0) begin failures++; $display("FAIL m0_underrun got=%0d exp=0", u_mark - u0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL m0_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_modes();
        logic [7:0] m0, m1;
        int r0, u0;
        for (int md = 0; md < 4; md++) begin
            r0 = rx_cnt; u0 = under_cnt;
            load_tx(8'h81);
            frame_start(md[1], md[0]);
            load_tx(8'h7E);
            spi_xfer(8'h12, 8, m0);
            spi_xfer(8'h34, 8, m1);
            frame_end();
            checks++; if (m0 !== 8'h81) begin failures++; $display("FAIL mode%0d_master_w0 got=%h exp=81", md, m0); end
            checks++; if (m1 !== 8'h7E) begin failures++; $display("FAIL mode%0d_master_w1 got=%h exp=7e", md, m1); end
            checks++; if (rx_cnt - r0 != 2) begin failures++; $display("FAIL mode%0d_rx_pulses got=%0d exp=2", md, rx_cnt - r0); end
            checks++; if (rx_log[r0 % 16] !== 8'h12) begin failures++; $display("FAIL mode%0d_rx_w0 got=%h exp=12", md, rx_log[r0 % 16]); end
            checks++; if (rx_log[(r0 + 1) % 16] !== 8'h34) begin failures++; $display("FAIL mode%0d_rx_w1 got=%h exp=34", md, rx_log[(r0 + 1) % 16]); end
            checks++; if (u_mark - u0 != 0) begin failures++; $display("FAIL mode%0d_underrun got=%0d exp=0", md, u_mark - u0); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] m;
        int r0, u0;
        r0 = rx_cnt; u0 = under_cnt;
        frame_start(1'b0, 1'b0);
        checks++; if (under_cnt - u0 != 1) begin failures++; $display("FAIL ur_start_pulse got=%0d exp=1", under_cnt - u0); end
        spi_xfer(8'h55, 8, m);
        frame_end();
        checks++; if (m !== 8'hFF) begin failures++; $display("FAIL ur_master_rx got=%h exp=ff", m); end
        checks++; if (u_mark - u0 != 1) begin failures++; $display("FAIL ur_pulses got=%0d exp=1", u_mark - u0); end
        checks++; if (rx_log[r0 % 16] !== 8'h55) begin failures++; $display("FAIL ur_rx_data got=%h exp=55", rx_log[r0 % 16]); end
    endtask

    task automatic test_collision();
        logic [7:0] m0, m1;
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        wait_clk(6);
        csb = 1'b0;
        wait_clk(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL col_pre_busy got=%b exp=0", busy); end
        tx_data = 8'hC3; tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL col_busy got=%b exp=1", busy); end
        checks++; if (tx_underrun !== 1'b1) begin failures++; $display("FAIL col_underrun got=%b exp=1", tx_underrun); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL col_ready got=%b exp=0", tx_ready); end
        wait_clk(4);
        spi_xfer(8'hA1, 8, m0);
        spi_xfer(8'hB2, 8, m1);
        frame_end();
        checks++; if (m0 !== 8'hFF) begin failures++; $display("FAIL col_w0 got=%h exp=ff", m0); end
        checks++; if (m1 !== 8'hC3) begin failures++; $display("FAIL col_w1 got=%h exp=c3", m1); end
    endtask

    task automatic test_frame_err();
        logic [7:0] m;
        int r0, f0;
        r0 = rx_cnt; f0 = ferr_cnt;
        load_tx(8'h5A);
        frame_start(1'b0, 1'b0);
        spi_xfer(8'hE0, 5, m);
        frame_end();
        checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL fe_pulses got=%0d exp=1", ferr_cnt - f0); end
        checks++; if (rx_cnt != r0) begin failures++; $display("FAIL fe_no_rx got=%0d exp=0", rx_cnt - r0); end
        checks++; if (m !== 8'h0B) begin failures++; $display("FAIL fe_partial got=%h exp=0b", m); end
        load_tx(8'h96);
        frame_start(1'b0, 1'b0);
        spi_xfer(8'hC7, 8, m);
        frame_end();
        checks++; if (m !== 8'h96) begin failures++; $display("FAIL fe_next_master got=%h exp=96", m); end
        checks++; if (rx_cnt - r0 != 1 || rx_log[r0 % 16] !== 8'hC7) begin failures++; $display("FAIL fe_next_rx got=%h cnt=%0d exp=c7 cnt=1", rx_log[r0 % 16], rx_cnt - r0); end
        checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL fe_next_ferr got=%0d exp=1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        int r0, f0;
        load_tx(8'h11);
        frame_start(1'b0, 1'b0);
        spi_xfer(8'hF0, 3, m);
        r0 = rx_cnt; f0 = ferr_cnt;
        rst_n = 1'b0;
        wait_clk(2);
        test_reset();
        rst_n = 1'b1;
        wait_clk(4);
        spi_xfer(8'hAA, 8, m);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
        checks++; if (rx_cnt != r0) begin failures++; $display("FAIL rm_no_rx got=%0d exp=0", rx_cnt - r0); end
        frame_end();
        checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL rm_no_ferr got=%0d exp=0", ferr_cnt - f0); end
        frame_start(1'b0, 1'b0);
        spi_xfer(8'h3A, 8, m);
        frame_end();
        checks++; if (rx_cnt - r0 != 1 || rx_log[r0 % 16] !== 8'h3A) begin failures++; $display("FAIL rm_new_rx got=%h cnt=%0d exp=3a cnt=1", rx_log[r0 % 16], rx_cnt - r0); end
    endtask

    initial begin
        rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        wait_clk(3);
        test_reset();
        rst_n = 1'b1;
        wait_clk(6);
        test_mode0();
        test_modes();
        test_underrun();
        test_collision();
        test_frame_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
